matrix_4x4_sched: RTL and testbench

// - Round-robin scheduler that shares one 4x4 fixed-point matrix-multiply unit (input buffer + multiplier) among NREQ requesters.
// - Collects a job of 16 (a,b) word pairs from the granted requester and stages them internally.
// - Issues the job to the input buffer as one handshake followed by a gap-free 16-cycle stream.
// - Routes the 16-word result stream back to the owner, then re-arbitrates.

---
 rtl/matrix_4x4_sched.sv | 155 +++++++++++++++
 tb/tb_matrix_4x4_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_4x4_sched.sv
// Round-robin front end sharing one 4x4 matrix-multiply unit among NREQ requesters.
// Stages a 16-pair job, streams it gap-free to the input buffer, then routes 16 results back.
module matrix_4x4_sched #(
  parameter int NREQ  = 4,
  parameter int W     = 12,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*W-1:0]         req_a,
  input  logic [NREQ*W-1:0]         req_b,
  output logic                      mm_valid,
  input  logic                      mm_ready,
  output logic [W-1:0]              mm_a,
  output logic [W-1:0]              mm_b,
  input  logic                      mm_c_valid,
  output logic                      mm_c_ready,
  input  logic [W-1:0]              mm_c,
  output logic [NREQ-1:0]           res_valid,
  input  logic [NREQ-1:0]           res_ready,
  output logic [W-1:0]              res_c,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          jobs_done
);
  localparam int GID_W = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, STREAM, RESULT} state_t;
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  state_t           state, state_nxt;
  pair_t            stage [16];
  pair_t            cur_pair;
  logic [3:0]       k, k_inc;
  logic             last;
  logic [GID_W-1:0] rr_ptr, pick, rr_nxt;
  logic             pick_vld;
  logic             load_xfer, res_xfer;

  assign k_inc = k + 4'd1;
  assign last  = (k == 4'd15);

  // first valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      idx = (int'(rr_ptr) + j) % NREQ;
      if (!pick_vld && req_valid[idx]) begin
        pick_vld = 1'b1;
        pick     = GID_W'(idx);
      end
    end
  end

  always_comb begin
    cur_pair.a = req_a[int'(grant_id)*W +: W];
    cur_pair.b = req_b[int'(grant_id)*W +: W];
    rr_nxt     = (int'(grant_id) == NREQ-1) ? '0 : grant_id + GID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    mm_valid   = 1'b0;
    mm_c_ready = 1'b0;
    res_valid  = '0;
    res_c      = '0;
    load_xfer  = 1'b0;
    res_xfer   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:   if (pick_vld) state_nxt = LOAD;
      LOAD: begin
        req_ready[grant_id] = 1'b1;
        load_xfer           = req_valid[grant_id];
        if (load_xfer && last) state_nxt = ISSUE;
      end
      ISSUE: begin
        mm_valid = 1'b1;
        if (mm_ready) state_nxt = STREAM;
      end
      STREAM: if (last) state_nxt = RESULT;
      RESULT: begin
        res_c               = mm_c;
        res_valid[grant_id] = mm_c_valid;
        mm_c_ready          = res_ready[grant_id];
        res_xfer            = mm_c_valid && res_ready[grant_id];
        if (res_xfer && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // staging RAM carries no reset; its contents only matter after a full LOAD
  always_ff @(posedge clk) begin
    if (state == LOAD && load_xfer) stage[k] <= cur_pair;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k         <= '0;
      rr_ptr    <= '0;
      grant_id  <= '0;
      jobs_done <= '0;
      mm_a      <= '0;
      mm_b      <= '0;
    end else begin
      case (state)
        IDLE:   if (pick_vld) grant_id <= pick;
        LOAD:   if (load_xfer) k <= k_inc;
        ISSUE: begin
          if (mm_ready) begin
            mm_a <= stage[0].a;
            mm_b <= stage[0].b;
            k    <= '0;
          end
        end
        STREAM: begin
          // the buffer samples every cycle, so the stream never stalls
          if (last) begin
            mm_a <= '0;
            mm_b <= '0;
            k    <= '0;
          end else begin
            mm_a <= stage[k_inc].a;
            mm_b <= stage[k_inc].b;
            k    <= k_inc;
          end
        end
        RESULT: begin
          if (res_xfer) begin
            k <= k_inc;
            if (last) begin
              rr_ptr    <= rr_nxt;
              jobs_done <= jobs_done + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_4x4_sched.sv
// Randomized bench for matrix_4x4_sched against a job-level scheduler model.
module tb_matrix_4x4_sched;
  localparam int NREQ  = 4;
  localparam int W     = 12;
  localparam int CNT_W = 16;
  localparam int GW    = $clog2(NREQ);

  logic                clk, rst_n;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [NREQ*W-1:0]   req_a, req_b;
  logic                mm_valid, mm_ready;
  logic [W-1:0]        mm_a, mm_b;
  logic                mm_c_valid, mm_c_ready;
  logic [W-1:0]        mm_c;
  logic [NREQ-1:0]     res_valid, res_ready;
  logic [W-1:0]        res_c;
  logic [GW-1:0]       grant_id;
  logic                busy;
  logic [CNT_W-1:0]    jobs_done;

  matrix_4x4_sched #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mm_valid(mm_valid), .mm_ready(mm_ready), .mm_a(mm_a), .mm_b(mm_b),
    .mm_c_valid(mm_c_valid), .mm_c_ready(mm_c_ready), .mm_c(mm_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_c(res_c),
    .grant_id(grant_id), .busy(busy), .jobs_done(jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // requester side: each requester holds at most one 16-pair job
  logic [W-1:0]   ja [NREQ][16];
  logic [W-1:0]   jb [NREQ][16];
  int             ptr [NREQ];
  bit             has_job [NREQ];
  bit [NREQ-1:0]  active;
  int             bubble, rdy_pct, cv_pct, rr_pct;
  bit             tog, par, rst_mid;

  // scheduler model: phase 0 free, 1 collecting, 2 awaiting buffer, 3 streaming, 4 returning
  int             ph, cnt, owner, rr, mgid, done;
  logic [W-1:0]   sa [16];
  logic [W-1:0]   sb [16];
  int             grants [$];

  task automatic new_job(input int i);
    for (int k = 0; k < 16; k++) begin
      ja[i][k] = W'($urandom);
      jb[i][k] = W'($urandom);
    end
    ptr[i]     = 0;
    has_job[i] = 1'b1;
  endtask

  task automatic reset_model();
    ph = 0; cnt = 0; owner = 0; rr = 0; mgid = 0; done = 0;
  endtask

  task automatic cycle();
    logic [NREQ-1:0] exp_rdy, exp_rv;
    int  idx;
    bit  found;
    @(negedge clk);
    rst_n = 1'b1;
    par   = ~par;
    for (int i = 0; i < NREQ; i++) begin
      if (!has_job[i] && active[i] && $urandom_range(0, 9) == 0) new_job(i);
      if (has_job[i] && $urandom_range(0, 99) >= bubble) begin
        req_valid[i]       = 1'b1;
        req_a[i*W +: W]    = ja[i][ptr[i]];
        req_b[i*W +: W]    = jb[i][ptr[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_a[i*W +: W]    = W'($urandom);
        req_b[i*W +: W]    = W'($urandom);
      end
      res_ready[i] = tog ? par : ($urandom_range(0, 99) < rr_pct);
    end
    mm_ready   = ($urandom_range(0, 99) < rdy_pct);
    mm_c_valid = ($urandom_range(0, 99) < cv_pct);
    mm_c       = W'($urandom);
    #1;
    exp_rdy = (ph == 1) ? (NREQ'(1) << owner) : '0;
    exp_rv  = (ph == 4 && mm_c_valid) ? (NREQ'(1) << owner) : '0;
    chk("busy",       busy,       ph != 0);
    chk("req_ready",  req_ready,  exp_rdy);
    chk("mm_valid",   mm_valid,   ph == 2);
    chk("mm_a",       mm_a,       (ph == 3) ? sa[cnt] : '0);
    chk("mm_b",       mm_b,       (ph == 3) ? sb[cnt] : '0);
    chk("res_valid",  res_valid,  exp_rv);
    chk("mm_c_ready", mm_c_ready, ph == 4 && res_ready[owner]);
    chk("res_c",      res_c,      (ph == 4) ? mm_c : '0);
    chk("grant_id",   grant_id,   mgid);
    chk("jobs_done",  jobs_done,  done);
    if (rst_mid && ph == 3 && cnt == 7) begin
      rst_n   = 1'b0;
      rst_mid = 1'b0;
      reset_model();
    end else begin
      case (ph)
        0: begin
          found = 1'b0;
          for (int j = 0; j < NREQ; j++) begin
            idx = (rr + j) % NREQ;
            if (!found && req_valid[idx]) begin
              found = 1'b1; owner = idx; mgid = idx; ph = 1; cnt = 0;
              grants.push_back(idx);
            end
          end
        end
        1: if (req_valid[owner]) begin
          sa[cnt] = ja[owner][ptr[owner]];
          sb[cnt] = jb[owner][ptr[owner]];
          ptr[owner]++;
          cnt++;
          if (ptr[owner] == 16) has_job[owner] = 1'b0;
          if (cnt == 16) ph = 2;
        end
        2: if (mm_ready) begin ph = 3; cnt = 0; end
        3: begin
          cnt++;
          if (cnt == 16) begin ph = 4; cnt = 0; end
        end
        4: if (mm_c_valid && res_ready[owner]) begin
          cnt++;
          if (cnt == 16) begin
            ph = 0; cnt = 0; rr = (owner + 1) % NREQ; done++;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic run_until(input int target, input int budget);
    int c = 0;
    while (done < target && c < budget) begin
      cycle();
      c++;
    end
    chk("jobs_reached", done, target);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    mm_ready = 1'b0; mm_c_valid = 1'b0; mm_c = '0; res_ready = '0;
    for (int i = 0; i < NREQ; i++) begin has_job[i] = 1'b0; ptr[i] = 0; end
    active = '0; bubble = 0; rdy_pct = 100; cv_pct = 100; rr_pct = 100;
    tog = 1'b0; par = 1'b0; rst_mid = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);

    // two simultaneous requesters from rr_ptr=0: 1 then 3
    new_job(1); new_job(3);
    run_until(2, 400);
    chk("grant_count", grants.size(), 2);
    if (grants.size() >= 2) begin
      chk("grant_first",  grants[0], 1);
      chk("grant_second", grants[1], 3);
    end

    // everyone competing, with requester bubbles and buffer/result back-pressure
    active = '1; bubble = 30; rdy_pct = 40; cv_pct = 70; rr_pct = 50;
    run_until(14, 6000);

    // long ISSUE stalls and res_ready toggling every cycle
    bubble = 0; rdy_pct = 5; cv_pct = 100; tog = 1'b1;
    run_until(16, 2000);

    // reset in the middle of a stream, then fresh jobs from a clean state
    tog = 1'b0; rdy_pct = 100; rr_pct = 80; rst_mid = 1'b1;
    for (int c = 0; c < 2000 && rst_mid; c++) cycle();
    chk("reset_hit", rst_mid, 0);
    run_until(3, 2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
